divisor_multicanal: RTL and testbench

//  N-channel programmable clock/tick divider; successor to the fixed 1 Hz divider.

---
 rtl/divisor_multicanal.sv | 105 ++++++++++
 tb/tb_divisor_multicanal.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_multicanal.sv
// N-channel programmable tick/clock divider with shadowed divisors, pulse or
// square output per channel, per-channel enable and a shared count enable.
module divisor_multicanal #(
  parameter int N_CH        = 4,
  parameter int DIV_WIDTH   = 26,
  parameter int DEFAULT_DIV = 49999999,
  localparam int AW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic                 iCe,
  input  logic [N_CH-1:0]      iEn,
  input  logic                 iWr,
  input  logic [AW-1:0]        iWrAddr,
  input  logic [DIV_WIDTH-1:0] iWrDiv,
  input  logic                 iWrMode,
  output logic [N_CH-1:0]      oTick,
  output logic [N_CH-1:0]      oClk,
  output logic                 oWrErr
);

  typedef logic [DIV_WIDTH-1:0] div_t;
  localparam div_t RST_DIV = div_t'(DEFAULT_DIV);

  div_t            cnt_q     [N_CH];
  div_t            cnt_d     [N_CH];
  div_t            act_div_q [N_CH];
  div_t            act_div_d [N_CH];
  div_t            sh_div_q  [N_CH];
  div_t            sh_div_d  [N_CH];
  logic [N_CH-1:0] act_mode_q, act_mode_d;
  logic [N_CH-1:0] sh_mode_q, sh_mode_d;
  logic [N_CH-1:0] tick_q, tick_d;
  logic [N_CH-1:0] clk_q, clk_d;
  logic            wrerr_q, wrerr_d;

  always_comb begin
    wrerr_d = iWr && ({1'b0, iWrAddr} >= (AW+1)'(N_CH));
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_d[c]      = cnt_q[c];
      act_div_d[c]  = act_div_q[c];
      act_mode_d[c] = act_mode_q[c];
      sh_div_d[c]   = sh_div_q[c];
      sh_mode_d[c]  = sh_mode_q[c];
      tick_d[c]     = 1'b0;
      // Between wraps a square output holds its level; a pulse output drops.
      clk_d[c]      = act_mode_q[c] ? clk_q[c] : 1'b0;

      if (!iEn[c]) begin
        cnt_d[c]      = '0;
        clk_d[c]      = 1'b0;
        act_div_d[c]  = sh_div_q[c];
        act_mode_d[c] = sh_mode_q[c];
      end else if (iCe) begin
        if (cnt_q[c] == act_div_q[c]) begin
          cnt_d[c]      = '0;
          tick_d[c]     = 1'b1;
          // Level for this wrap follows the mode of the period just ending,
          // so a mode change never shortens a half-period.
          clk_d[c]      = act_mode_q[c] ? ~clk_q[c] : 1'b1;
          act_div_d[c]  = sh_div_q[c];
          act_mode_d[c] = sh_mode_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end

      if (iWr && (iWrAddr == AW'(c))) begin
        sh_div_d[c]  = iWrDiv;
        sh_mode_d[c] = iWrMode;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt_q[c]     <= '0;
        act_div_q[c] <= RST_DIV;
        sh_div_q[c]  <= RST_DIV;
      end
      act_mode_q <= '0;
      sh_mode_q  <= '0;
      tick_q     <= '0;
      clk_q      <= '0;
      wrerr_q    <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt_q[c]     <= cnt_d[c];
        act_div_q[c] <= act_div_d[c];
        sh_div_q[c]  <= sh_div_d[c];
      end
      act_mode_q <= act_mode_d;
      sh_mode_q  <= sh_mode_d;
      tick_q     <= tick_d;
      clk_q      <= clk_d;
      wrerr_q    <= wrerr_d;
    end
  end

  assign oTick  = tick_q;
  assign oClk   = clk_q;
  assign oWrErr = wrerr_q;

endmodule

// File: tb/tb_divisor_multicanal.sv
// Bench for divisor_multicanal: countdown-based reference model checked every
// cycle, plus directed period/width/error/reset checks with literal values.
module tb_divisor_multicanal;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int DD = 9;
  localparam int AW = 2;

  logic          iClk = 1'b0;
  logic          iReset_n = 1'b1;
  logic          iCe = 1'b0;
  logic [N-1:0]  iEn = '0;
  logic          iWr = 1'b0;
  logic [AW-1:0] iWrAddr = '0;
  logic [W-1:0]  iWrDiv = '0;
  logic          iWrMode = 1'b0;
  logic [N-1:0]  oTick;
  logic [N-1:0]  oClk;
  logic          oWrErr;

  divisor_multicanal #(.N_CH(N), .DIV_WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iCe(iCe), .iEn(iEn), .iWr(iWr),
    .iWrAddr(iWrAddr), .iWrDiv(iWrDiv), .iWrMode(iWrMode),
    .oTick(oTick), .oClk(oClk), .oWrErr(oWrErr)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Reference model: cycles remaining in the current period, shadow/active
  // settings and the output levels they imply.
  int m_rem      [N];
  int m_act_div  [N];
  bit m_act_mode [N];
  int m_sh_div   [N];
  bit m_sh_mode  [N];
  bit m_tick     [N];
  bit m_clk      [N];
  bit m_err;

  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int c = 0; c < N; c++) begin
        m_act_div[c] = DD; m_sh_div[c] = DD; m_act_mode[c] = 0; m_sh_mode[c] = 0;
        m_rem[c] = DD + 1; m_tick[c] = 0; m_clk[c] = 0;
      end
      m_err = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (!iEn[c]) begin
          m_act_div[c] = m_sh_div[c]; m_act_mode[c] = m_sh_mode[c];
          m_rem[c] = m_act_div[c] + 1; m_tick[c] = 0; m_clk[c] = 0;
        end else if (iCe && m_rem[c] == 1) begin
          m_tick[c] = 1;
          m_clk[c]  = m_act_mode[c] ? !m_clk[c] : 1'b1;
          m_act_div[c] = m_sh_div[c]; m_act_mode[c] = m_sh_mode[c];
          m_rem[c] = m_act_div[c] + 1;
        end else begin
          if (iCe) m_rem[c] = m_rem[c] - 1;
          m_tick[c] = 0;
          if (!m_act_mode[c]) m_clk[c] = 0;
        end
      end
      m_err = iWr && (int'(iWrAddr) >= N);
      if (iWr && int'(iWrAddr) < N) begin
        m_sh_div[int'(iWrAddr)]  = int'(iWrDiv);
        m_sh_mode[int'(iWrAddr)] = iWrMode;
      end
    end
  end

  always @(negedge iClk) begin
    logic [N-1:0] et, ec;
    if (chk_en && iReset_n) begin
      for (int c = 0; c < N; c++) begin
        et[c] = m_tick[c];
        ec[c] = m_clk[c];
      end
      tests++;
      if (oTick !== et || oClk !== ec || oWrErr !== m_err) begin
        fails++;
        $display("FAIL model t=%0t tick=%b/%b clk=%b/%b err=%b/%b (actual/required)",
                 $time, oTick, et, oClk, ec, oWrErr, m_err);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_write(input int addr, input int div, input bit mode);
    iWr = 1'b1; iWrAddr = AW'(addr); iWrDiv = W'(div); iWrMode = mode;
    @(negedge iClk);
    iWr = 1'b0;
  endtask

  // Waits for a tick on ch, then counts cycles to the next tick.
  task automatic measure(input int ch, input int exp, input string name);
    bit ok = 0;
    int n = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge iClk);
      if (oTick[ch]) ok = 1;
    end
    if (!ok) begin
      check({name, "_timeout"}, 0, 1);
      return;
    end
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge iClk);
      n++;
      if (oTick[ch]) ok = 1;
    end
    check(name, n, exp);
  endtask

  task automatic wait_level(input int ch, input bit lvl, input string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge iClk);
      if (oClk[ch] == lvl) ok = 1;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, last;
    bit ok;

    #2 iReset_n = 1'b0;
    #1 check("reset_outputs", int'({oTick, oClk, oWrErr}), 0);
    iCe = 1'b1; iEn = '1;
    @(negedge iClk);
    #2 iReset_n = 1'b1;
    chk_en = 1;

    // Default divisor 9: tick every 10 cycles, one cycle wide.
    measure(0, 10, "t1_period");
    @(negedge iClk);
    check("t1_width", int'(oTick[0]), 0);

    // Channel 1 square mode, D=3.
    do_write(1, 3, 1'b1);
    measure(1, 4, "t2_tick_period");
    wait_level(1, 1'b0, "t2_sync_low");
    wait_level(1, 1'b1, "t2_sync_high");
    n = 1; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      if (!oClk[1]) ok = 1; else n++;
    end
    check("t2_high_len", n, 4);
    n = 1; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      if (oClk[1]) ok = 1; else n++;
    end
    check("t2_low_len", n, 4);

    // Write D=4 to ch0 at count 5: current period stays 10.
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      if (oTick[0]) ok = 1;
    end
    repeat (5) @(negedge iClk);
    iWr = 1'b1; iWrAddr = 2'd0; iWrDiv = W'(4); iWrMode = 1'b0;
    @(negedge iClk);
    iWr = 1'b0;
    n = 6; ok = oTick[0];
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      n++;
      if (oTick[0]) ok = 1;
    end
    check("t3_old_period", n, 10);
    n = 0; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      n++;
      if (oTick[0]) ok = 1;
    end
    check("t3_new_period", n, 5);

    // Channel 2 D=1 under a 1-of-3 count enable.
    do_write(2, 1, 1'b0);
    iEn[2] = 1'b0;
    @(negedge iClk);
    iEn[2] = 1'b1;
    last = -1;
    for (int k = 0; k < 60; k++) begin
      if (oTick[2]) begin
        if (last >= 0) check("t4_ce_period", k - last, 6);
        last = k;
      end
      iCe = (k % 3 == 0);
      @(negedge iClk);
    end
    iCe = 1'b1;
    repeat (3) @(negedge iClk);
    iEn[2] = 1'b0;
    @(negedge iClk);
    check("t4_disable", int'({oTick[2], oClk[2]}), 0);
    iEn[2] = 1'b1;
    n = 0; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge iClk);
      n++;
      if (oTick[2]) ok = 1;
    end
    check("t4_reenable", n, 2);

    // Out-of-range write address.
    do_write(3, 0, 1'b1);
    check("t5_err_pulse", int'(oWrErr), 1);
    @(negedge iClk);
    check("t5_err_clear", int'(oWrErr), 0);
    measure(0, 5, "t5_ch0_unchanged");

    // Asynchronous reset between edges.
    repeat (4) @(negedge iClk);
    #2 iReset_n = 1'b0;
    #1 check("t6_async_reset", int'({oTick, oClk, oWrErr}), 0);
    #4 iReset_n = 1'b1;
    measure(1, 10, "t6_ch1_default");
    check("t6_ch1_mode0", int'(oClk[1]), 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge iClk);
      iCe = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) iEn[c] = ($urandom_range(0, 7) != 0);
      iWr = ($urandom_range(0, 5) == 0);
      iWrAddr = AW'($urandom_range(0, 3));
      iWrDiv = W'($urandom_range(0, 7));
      iWrMode = 1'($urandom_range(0, 1));
    end
    @(negedge iClk);
    iWr = 1'b0;
    @(negedge iClk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
